// File: rtl/demux_switchover_ctrl_if.sv
// Request, stream-observation and status signals between the control block,
// the demux datapath and the switchover sequencer.
interface demux_switchover_ctrl_if #(
    parameter int M_COUNT    = 2,
    parameter int CL_M_COUNT = $clog2(M_COUNT)
);
    logic [CL_M_COUNT-1:0] cfg_select;
    logic                  cfg_disable_rm;
    logic                  in_tvalid;
    logic                  in_tready;
    logic                  in_tlast;
    logic                  out_tvalid;
    logic                  out_tready;
    logic                  out_tlast;
    logic                  block_ingress;
    logic [CL_M_COUNT-1:0] active_select;
    logic                  active_disable_rm;
    logic                  busy;
    logic                  timeout_flag;
    logic                  underflow_flag;

    modport slave (
        input  cfg_select, cfg_disable_rm,
        input  in_tvalid, in_tready, in_tlast,
        input  out_tvalid, out_tready, out_tlast,
        output block_ingress, active_select, active_disable_rm,
        output busy, timeout_flag, underflow_flag
    );

    modport master (
        output cfg_select, cfg_disable_rm,
        output in_tvalid, in_tready, in_tlast,
        output out_tvalid, out_tready, out_tlast,
        input  block_ingress, active_select, active_disable_rm,
        input  busy, timeout_flag, underflow_flag
    );
endinterface

// File: rtl/demux_switchover_ctrl.sv
// Sequences a safe demux/RM reconfiguration: gate ingress at a packet boundary,
// drain in-flight packets, apply the new configuration, then hold for a settle interval.
module demux_switchover_ctrl #(
    parameter int M_COUNT       = 2,
    parameter int CL_M_COUNT    = $clog2(M_COUNT),
    parameter int OUT_W         = 8,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                   axil_aclk,
    input  logic                   axil_aresetn,
    demux_switchover_ctrl_if.slave ctrl
);
    localparam int DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST  = DRAIN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [OUT_W-1:0]    OUT_MAX     = '1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] QUIESCE = 3'd1;
    localparam logic [2:0] DRAIN   = 3'd2;
    localparam logic [2:0] APPLY   = 3'd3;
    localparam logic [2:0] SETTLE  = 3'd4;

    logic [2:0]            state_reg, state_next;
    logic                  mid_pkt_reg, mid_pkt_next;
    logic [OUT_W-1:0]      outstanding_reg, outstanding_next;
    logic [DRAIN_W-1:0]    drain_cnt_reg, drain_cnt_next;
    logic [SETTLE_W-1:0]   settle_cnt_reg, settle_cnt_next;
    logic [CL_M_COUNT-1:0] req_select_reg, req_select_next;
    logic                  req_disable_rm_reg, req_disable_rm_next;
    logic [CL_M_COUNT-1:0] active_select_reg, active_select_next;
    logic                  active_disable_rm_reg, active_disable_rm_next;
    logic                  block_ingress_reg, block_ingress_next;
    logic                  timeout_flag_reg, timeout_flag_next;
    logic                  underflow_flag_reg, underflow_flag_next;

    logic ing_hs;
    logic ing_last;
    logic egr_last;

    assign ing_hs   = ctrl.in_tvalid & ctrl.in_tready;
    assign ing_last = ing_hs & ctrl.in_tlast;
    assign egr_last = ctrl.out_tvalid & ctrl.out_tready & ctrl.out_tlast;

    // Packet-boundary and in-flight tracking runs in every state.
    always_comb begin : track_comb
        mid_pkt_next        = mid_pkt_reg;
        outstanding_next    = outstanding_reg;
        underflow_flag_next = underflow_flag_reg;
        if (ing_hs) begin
            mid_pkt_next = ~ctrl.in_tlast;
        end
        if (ing_last && !egr_last) begin
            if (outstanding_reg != OUT_MAX) begin
                outstanding_next = outstanding_reg + 1'b1;
            end
        end else if (!ing_last && egr_last) begin
            if (outstanding_reg == '0) begin
                underflow_flag_next = 1'b1;
            end else begin
                outstanding_next = outstanding_reg - 1'b1;
            end
        end
    end

    always_comb begin : fsm_comb
        state_next             = state_reg;
        drain_cnt_next         = drain_cnt_reg;
        settle_cnt_next        = settle_cnt_reg;
        req_select_next        = req_select_reg;
        req_disable_rm_next    = req_disable_rm_reg;
        active_select_next     = active_select_reg;
        active_disable_rm_next = active_disable_rm_reg;
        block_ingress_next     = block_ingress_reg;
        timeout_flag_next      = timeout_flag_reg;
        case (state_reg)
            IDLE: begin
                if ({ctrl.cfg_select, ctrl.cfg_disable_rm} !=
                    {active_select_reg, active_disable_rm_reg}) begin
                    req_select_next     = ctrl.cfg_select;
                    req_disable_rm_next = ctrl.cfg_disable_rm;
                    state_next          = QUIESCE;
                end
            end
            QUIESCE: begin
                // Close the gate only once this cycle's beat leaves us on a boundary.
                if (!mid_pkt_next) begin
                    block_ingress_next = 1'b1;
                    drain_cnt_next     = '0;
                    state_next         = DRAIN;
                end
            end
            DRAIN: begin
                drain_cnt_next = drain_cnt_reg + 1'b1;
                if (outstanding_reg == '0 || drain_cnt_reg == DRAIN_LAST) begin
                    timeout_flag_next      = timeout_flag_reg | (outstanding_reg != '0);
                    // Loaded on entry so the demux sees the new values during APPLY.
                    active_select_next     = req_select_reg;
                    active_disable_rm_next = req_disable_rm_reg;
                    state_next             = APPLY;
                end
            end
            APPLY: begin
                settle_cnt_next = '0;
                state_next      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_reg == SETTLE_LAST) begin
                    block_ingress_next = 1'b0;
                    state_next         = IDLE;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            state_reg             <= IDLE;
            mid_pkt_reg           <= 1'b0;
            outstanding_reg       <= '0;
            drain_cnt_reg         <= '0;
            settle_cnt_reg        <= '0;
            req_select_reg        <= '0;
            req_disable_rm_reg    <= 1'b0;
            active_select_reg     <= '0;
            active_disable_rm_reg <= 1'b0;
            block_ingress_reg     <= 1'b0;
            timeout_flag_reg      <= 1'b0;
            underflow_flag_reg    <= 1'b0;
        end else begin
            state_reg             <= state_next;
            mid_pkt_reg           <= mid_pkt_next;
            outstanding_reg       <= outstanding_next;
            drain_cnt_reg         <= drain_cnt_next;
            settle_cnt_reg        <= settle_cnt_next;
            req_select_reg        <= req_select_next;
            req_disable_rm_reg    <= req_disable_rm_next;
            active_select_reg     <= active_select_next;
            active_disable_rm_reg <= active_disable_rm_next;
            block_ingress_reg     <= block_ingress_next;
            timeout_flag_reg      <= timeout_flag_next;
            underflow_flag_reg    <= underflow_flag_next;
        end
    end

    assign ctrl.block_ingress     = block_ingress_reg;
    assign ctrl.active_select     = active_select_reg;
    assign ctrl.active_disable_rm = active_disable_rm_reg;
    assign ctrl.busy              = (state_reg != IDLE);
    assign ctrl.timeout_flag      = timeout_flag_reg;
    assign ctrl.underflow_flag    = underflow_flag_reg;
endmodule

// File: tb/tb_demux_switchover_ctrl.sv
// Scenario bench for demux_switchover_ctrl: expected active configurations are queued
// when cfg is driven and popped when the DUT's active outputs change.
module tb_demux_switchover_ctrl;
    localparam int M_COUNT = 2;
    localparam int CL      = 1;
    localparam int OUT_W   = 8;
    localparam int DT      = 64;
    localparam int SC      = 16;

    typedef logic [1:0] cfg_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ing_valid;
    logic ing_ready;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_apply = 0;
    cfg_t exp_q[$];

    always #5 clk = ~clk;

    demux_switchover_ctrl_if #(.M_COUNT(M_COUNT), .CL_M_COUNT(CL)) ctrl ();

    demux_switchover_ctrl #(
        .M_COUNT(M_COUNT), .CL_M_COUNT(CL), .OUT_W(OUT_W),
        .DRAIN_TIMEOUT(DT), .SETTLE_CYCLES(SC)
    ) dut (
        .axil_aclk(clk),
        .axil_aresetn(rst_n),
        .ctrl(ctrl)
    );

    // Downstream gating model: block_ingress forces the observed ingress handshake low.
    assign ctrl.in_tvalid = ing_valid & ~ctrl.block_ingress;
    assign ctrl.in_tready = ing_ready & ~ctrl.block_ingress;

    logic [1:0] act;
    logic [5:0] outs;
    assign act  = {ctrl.active_select, ctrl.active_disable_rm};
    assign outs = {ctrl.block_ingress, ctrl.busy, ctrl.active_select,
                   ctrl.active_disable_rm, ctrl.timeout_flag, ctrl.underflow_flag};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cfg_t sb_pop();
        cfg_t e;
        if (exp_q.size() == 0) begin
            e = 2'bxx;
        end else begin
            e = exp_q.pop_front();
        end
        n_apply++;
        $display("[TB] apply %0d: active sel=%0d dis=%0d expected %b", n_apply,
                 ctrl.active_select, ctrl.active_disable_rm, e);
        return e;
    endfunction

    task automatic wait_active_change(input int budget, output int cycles, output bit seen);
        cfg_t start;
        start  = act;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            tick();
            cycles++;
            if (act != start) seen = 1'b1;
        end
    endtask

    task automatic wait_busy_low(input int budget, output bit ok);
        int c;
        c  = 0;
        ok = 1'b0;
        while (!ok && c < budget) begin
            tick();
            c++;
            if (ctrl.busy == 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ctrl.cfg_select = '0; ctrl.cfg_disable_rm = 1'b0;
        ing_valid = 1'b0; ing_ready = 1'b0; ctrl.in_tlast = 1'b0;
        ctrl.out_tvalid = 1'b0; ctrl.out_tready = 1'b0; ctrl.out_tlast = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (outs !== 6'b0) begin n_fail++; $display("FAIL reset_hold: outs=%b required 000000", outs); end
        rst_n = 1'b1;
        tick(); tick();
        n_tests++;
        if (outs !== 6'b0) begin n_fail++; $display("FAIL reset_release: outs=%b required 000000", outs); end
    endtask

    task automatic test_idle_switch();
        int rise_at, apply_at, fall_at, busy_bad;
        cfg_t e;
        rise_at = -1; apply_at = -1; fall_at = -1; busy_bad = 0;
        ctrl.cfg_select = 1'b1;
        exp_q.push_back(2'b10);
        for (int k = 1; k <= SC + 8; k++) begin
            tick();
            if (rise_at < 0 && ctrl.block_ingress) rise_at = k;
            if (rise_at >= 0 && fall_at < 0 && !ctrl.block_ingress) fall_at = k;
            if (apply_at < 0 && act != 2'b00) begin
                apply_at = k;
                e = sb_pop();
                n_tests++;
                if (act !== e) begin n_fail++; $display("FAIL idle_apply_value: active=%b required %b", act, e); end
            end
            if (ctrl.busy !== ((k <= SC + 3) ? 1'b1 : 1'b0)) busy_bad++;
        end
        n_tests++;
        if (rise_at !== 2) begin n_fail++; $display("FAIL idle_block_rise: cycle %0d required 2", rise_at); end
        n_tests++;
        if (apply_at !== 3) begin n_fail++; $display("FAIL idle_apply_cycle: cycle %0d required 3", apply_at); end
        n_tests++;
        if (fall_at !== SC + 4) begin n_fail++; $display("FAIL idle_block_fall: cycle %0d required %0d", fall_at, SC + 4); end
        n_tests++;
        if (busy_bad !== 0) begin n_fail++; $display("FAIL idle_busy_window: %0d bad cycles required 0", busy_bad); end
    endtask

    task automatic test_mid_packet();
        cfg_t e;
        bit ok;
        ctrl.in_tlast = 1'b0; ing_valid = 1'b1; ing_ready = 1'b1;
        tick(); tick();
        ctrl.cfg_disable_rm = 1'b1;
        exp_q.push_back(2'b11);
        tick();
        n_tests++;
        if ({ctrl.block_ingress, ctrl.busy} !== 2'b01) begin
            n_fail++; $display("FAIL mid_quiesce: block,busy=%b required 01", {ctrl.block_ingress, ctrl.busy});
        end
        tick();
        n_tests++;
        if (ctrl.block_ingress !== 1'b0) begin n_fail++; $display("FAIL mid_beat4: block=%b required 0", ctrl.block_ingress); end
        ctrl.in_tlast = 1'b1;
        tick();
        n_tests++;
        if (ctrl.block_ingress !== 1'b1) begin n_fail++; $display("FAIL mid_last_beat: block=%b required 1", ctrl.block_ingress); end
        ing_valid = 1'b0; ctrl.in_tlast = 1'b0;
        repeat (5) tick();
        n_tests++;
        if ({ctrl.block_ingress, act} !== 3'b110) begin
            n_fail++; $display("FAIL mid_drain_hold: block,active=%b required 110", {ctrl.block_ingress, act});
        end
        ctrl.out_tvalid = 1'b1; ctrl.out_tready = 1'b1; ctrl.out_tlast = 1'b1;
        tick();
        ctrl.out_tvalid = 1'b0; ctrl.out_tready = 1'b0; ctrl.out_tlast = 1'b0;
        n_tests++;
        if (act !== 2'b10) begin n_fail++; $display("FAIL mid_pre_apply: active=%b required 10", act); end
        tick();
        e = sb_pop();
        n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL mid_apply: active=%b required %b", act, e); end
        wait_busy_low(SC + 10, ok);
        n_tests++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_settle_done: busy=%b required 0", ctrl.busy); end
    endtask

    task automatic test_drain_timeout();
        int to_at, apply_at, cyc;
        bit ok, seen;
        cfg_t e;
        to_at = -1; apply_at = -1;
        ctrl.in_tlast = 1'b1; ing_valid = 1'b1; ing_ready = 1'b1;
        tick(); tick();
        ing_valid = 1'b0; ctrl.in_tlast = 1'b0;
        ctrl.out_tvalid = 1'b1; ctrl.out_tready = 1'b0; ctrl.out_tlast = 1'b1;
        ctrl.cfg_select = 1'b0;
        exp_q.push_back(2'b01);
        for (int k = 1; k <= DT + 10; k++) begin
            tick();
            if (to_at < 0 && ctrl.timeout_flag) to_at = k;
            if (apply_at < 0 && act != 2'b11) begin
                apply_at = k;
                e = sb_pop();
                n_tests++;
                if (act !== e) begin n_fail++; $display("FAIL timeout_apply_value: active=%b required %b", act, e); end
            end
        end
        n_tests++;
        if (to_at !== DT + 2) begin n_fail++; $display("FAIL timeout_flag_cycle: cycle %0d required %0d", to_at, DT + 2); end
        n_tests++;
        if (apply_at !== DT + 2) begin n_fail++; $display("FAIL timeout_apply_cycle: cycle %0d required %0d", apply_at, DT + 2); end
        ctrl.out_tready = 1'b1;
        tick(); tick();
        ctrl.out_tvalid = 1'b0; ctrl.out_tready = 1'b0; ctrl.out_tlast = 1'b0;
        n_tests++;
        if (ctrl.underflow_flag !== 1'b0) begin n_fail++; $display("FAIL timeout_no_underflow: flag=%b required 0", ctrl.underflow_flag); end
        wait_busy_low(SC + 10, ok);
        ctrl.cfg_select = 1'b1;
        exp_q.push_back(2'b11);
        wait_active_change(DT + 10, cyc, seen);
        e = sb_pop();
        n_tests++;
        if (seen !== 1'b1 || cyc !== 3 || act !== e) begin
            n_fail++; $display("FAIL clean_after_timeout: seen=%b cycles=%0d active=%b required 1/3/%b", seen, cyc, act, e);
        end
        n_tests++;
        if (ctrl.timeout_flag !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: flag=%b required 1", ctrl.timeout_flag); end
        wait_busy_low(SC + 10, ok);
    endtask

    task automatic test_underflow();
        int cyc;
        bit ok, seen;
        cfg_t e;
        ctrl.in_tlast = 1'b1; ing_valid = 1'b1; ing_ready = 1'b1;
        tick();
        ctrl.out_tvalid = 1'b1; ctrl.out_tready = 1'b1; ctrl.out_tlast = 1'b1;
        tick();
        ing_valid = 1'b0; ctrl.in_tlast = 1'b0;
        tick();
        n_tests++;
        if (ctrl.underflow_flag !== 1'b0) begin n_fail++; $display("FAIL simul_hold: underflow=%b required 0", ctrl.underflow_flag); end
        tick();
        ctrl.out_tvalid = 1'b0; ctrl.out_tready = 1'b0; ctrl.out_tlast = 1'b0;
        n_tests++;
        if (ctrl.underflow_flag !== 1'b1) begin n_fail++; $display("FAIL underflow_set: underflow=%b required 1", ctrl.underflow_flag); end
        ctrl.cfg_select = 1'b0; ctrl.cfg_disable_rm = 1'b0;
        exp_q.push_back(2'b00);
        wait_active_change(DT + 10, cyc, seen);
        e = sb_pop();
        n_tests++;
        if (seen !== 1'b1 || cyc !== 3 || act !== e) begin
            n_fail++; $display("FAIL underflow_count_zero: seen=%b cycles=%0d active=%b required 1/3/%b", seen, cyc, act, e);
        end
        wait_busy_low(SC + 10, ok);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok, seen;
        cfg_t e;
        ctrl.in_tlast = 1'b1; ing_valid = 1'b1; ing_ready = 1'b1;
        tick();
        ing_valid = 1'b0; ctrl.in_tlast = 1'b0;
        ctrl.out_tvalid = 1'b1; ctrl.out_tready = 1'b0; ctrl.out_tlast = 1'b1;
        ctrl.cfg_select = 1'b1;
        exp_q.push_back(2'b10);
        tick(); tick();
        n_tests++;
        if ({ctrl.block_ingress, ctrl.busy} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_in_drain: block,busy=%b required 11", {ctrl.block_ingress, ctrl.busy});
        end
        ctrl.cfg_select = 1'b0;
        exp_q.push_back(2'b00);
        repeat (3) tick();
        ctrl.out_tready = 1'b1;
        tick();
        ctrl.out_tvalid = 1'b0; ctrl.out_tready = 1'b0; ctrl.out_tlast = 1'b0;
        wait_active_change(10, cyc, seen);
        e = sb_pop();
        n_tests++;
        if (seen !== 1'b1 || act !== e) begin n_fail++; $display("FAIL b2b_first: seen=%b active=%b required 1/%b", seen, act, e); end
        wait_active_change(SC + 12, cyc, seen);
        e = sb_pop();
        n_tests++;
        if (seen !== 1'b1 || cyc !== SC + 4 || act !== e) begin
            n_fail++; $display("FAIL b2b_second: seen=%b cycles=%0d active=%b required 1/%0d/%b", seen, cyc, act, e, SC + 4);
        end
        wait_busy_low(SC + 10, ok);
        n_tests++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: busy=%b required 0", ctrl.busy); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ok, seen;
        cfg_t e;
        ctrl.cfg_select = 1'b1; ctrl.cfg_disable_rm = 1'b1;
        exp_q.push_back(2'b11);
        wait_active_change(10, cyc, seen);
        e = sb_pop();
        n_tests++;
        if (seen !== 1'b1 || act !== e) begin n_fail++; $display("FAIL prereset_apply: seen=%b active=%b required 1/%b", seen, act, e); end
        repeat (4) tick();
        n_tests++;
        if ({ctrl.busy, ctrl.block_ingress, ctrl.timeout_flag, ctrl.underflow_flag} !== 4'b1111) begin
            n_fail++; $display("FAIL prereset_state: busy,block,flags=%b required 1111",
                               {ctrl.busy, ctrl.block_ingress, ctrl.timeout_flag, ctrl.underflow_flag});
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (outs !== 6'b0) begin n_fail++; $display("FAIL reset_async: outs=%b required 000000", outs); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back(2'b11);
        tick();
        n_tests++;
        if ({ctrl.busy, ctrl.block_ingress} !== 2'b10) begin
            n_fail++; $display("FAIL restart_busy: busy,block=%b required 10", {ctrl.busy, ctrl.block_ingress});
        end
        wait_active_change(10, cyc, seen);
        e = sb_pop();
        n_tests++;
        if (seen !== 1'b1 || cyc !== 2 || act !== e) begin
            n_fail++; $display("FAIL restart_apply: seen=%b cycles=%0d active=%b required 1/2/%b", seen, cyc, act, e);
        end
        wait_busy_low(SC + 10, ok);
    endtask

    initial begin
        test_reset();
        test_idle_switch();
        test_mid_packet();
        test_drain_timeout();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drained: %0d left required 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/demux_switchover_ctrl.md
Name: demux_switchover_ctrl

Overview:
- Sequences safe reconfiguration of the stream-switch demux and its DFX reconfigurable module (RM).
- Takes the committed select/disable_rm values from the AXI-Lite control block as requests.
- Before the active values change, it gates ingress at a packet boundary, drains in-flight packets, applies the new configuration, and waits a settle interval.
- Sits between the control register block and the demux datapath.

Parameters:
- M_COUNT, 2, number of demux outputs
- CL_M_COUNT, $clog2(M_COUNT), width of the select field
- OUT_W, 8, width of the outstanding-packet counter
- DRAIN_TIMEOUT, 4096, maximum DRAIN cycles before a forced apply
- SETTLE_CYCLES, 16, post-apply hold cycles before ingress reopens (must be ≥1)

Ports:
- axil_aclk  in  1  clock
- axil_aresetn  in  1  asynchronous active-low reset
- cfg_select  in  CL_M_COUNT  requested select (committed value from the control block)
- cfg_disable_rm  in  1  requested RM disable
- in_tvalid  in  1  ingress valid, observed after gating
- in_tready  in  1  ingress ready, observed after gating
- in_tlast  in  1  ingress last
- out_tvalid  in  1  egress valid (OR of demux outputs), observed
- out_tready  in  1  egress ready, observed
- out_tlast  in  1  egress last
- block_ingress  out  1  registered; 1 = downstream forces ingress tvalid/tready low
- active_select  out  CL_M_COUNT  select driven to the demux
- active_disable_rm  out  1  RM disable driven to the demux/decoupler
- busy  out  1  1 whenever state ≠ IDLE
- timeout_flag  out  1  sticky; a drain timed out
- underflow_flag  out  1  sticky; egress last seen with outstanding = 0

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs are 0; state = IDLE; counters = 0.
  - mid_pkt = 0; the latched request = 0.
  - Sticky flags clear only on reset.
- Event definitions:
  - ing_hs = in_tvalid & in_tready.
  - egr_last = out_tvalid & out_tready & out_tlast.
- mid_pkt tracking:
  - Set on ing_hs & ~in_tlast.
  - Cleared on ing_hs & in_tlast.
  - Tracked in every state.
- Outstanding counter:
  - +1 on ing_hs & in_tlast.
  - −1 on egr_last.
  - Both in the same cycle: unchanged.
  - Saturates at 2^OUT_W−1.
  - −1 at 0: count holds at 0 and underflow_flag is set.
- IDLE:
  - If {cfg_select, cfg_disable_rm} ≠ {active_select, active_disable_rm}: latch the request and go to QUIESCE.
  - Otherwise stay in IDLE.
- QUIESCE:
  - Compute the next value of mid_pkt this cycle.
  - If that next value is 0: block_ingress ← 1 and go to DRAIN with the timeout counter = 0.
  - A handshake in this same cycle is still counted.
  - Otherwise wait; there is no timeout in QUIESCE.
- DRAIN:
  - Increment the timeout counter each cycle.
  - If outstanding == 0 (registered value), go to APPLY.
  - Else, if the counter reaches DRAIN_TIMEOUT−1: set timeout_flag and go to APPLY (forced).
- APPLY (1 cycle):
  - active_select / active_disable_rm ← the latched request.
  - Settle counter = 0; go to SETTLE.
- SETTLE:
  - After SETTLE_CYCLES cycles, block_ingress ← 0 and go to IDLE.
  - IDLE re-compares cfg against active on the following cycle.
  - A cfg change that occurred mid-sequence therefore starts a new sequence; intermediate values are not tracked.
- cfg inputs are sampled only in IDLE; changes in other states do not alter the latched request.
- Latency: an idle link with outstanding = 0 runs cfg change → active update in 3 cycles (IDLE → QUIESCE → DRAIN → APPLY). block_ingress is high for SETTLE_CYCLES+2 cycles.
- Reset mid-sequence: immediately returns to IDLE. Active values revert to 0 and block_ingress drops to 0.
- Sizing: DRAIN_TIMEOUT counter is $clog2(DRAIN_TIMEOUT+1) bits; settle counter is $clog2(SETTLE_CYCLES+1) bits.

Test Plan:
- Idle link, cfg_select 0→1:
  - block_ingress rises 2 cycles after the change.
  - active_select = 1 on cycle 3.
  - block_ingress falls after 16 settle cycles; busy mirrors the whole window.
- Ingress mid-packet (3 of 5 beats sent) when cfg_disable_rm 0→1:
  - block_ingress stays 0 until the cycle the 5th beat (tlast) handshakes, then rises.
  - Outstanding = 1; active_disable_rm changes only after egr_last.
- Egress stalled (out_tready = 0) with 2 packets outstanding, DRAIN_TIMEOUT = 64:
  - timeout_flag sets after 64 DRAIN cycles and the apply is forced.
  - The flag remains set through a later clean switch.
- Simultaneous ing last and egr_last with outstanding = 1: count stays 1. Egr_last alone at count 0: count 0, underflow_flag = 1.
- cfg_select changes 0→1 then 1→0 while in DRAIN:
  - Sequence 1 applies select = 1.
  - Back in IDLE, a second sequence starts and ends with select = 0.
- Assert axil_aresetn low during SETTLE:
  - Asynchronously block_ingress = 0, busy = 0, active_select = 0, flags cleared.
  - After release, a nonzero cfg starts a new sequence.
